// File: rtl/fifo_sync_flags.sv
// Synchronous circular-buffer FIFO with full/almost-full/count flags and one-cycle error pulses.
// Define FIFO_FWFT_EN for first-word fall-through reads; default is a registered read with latency 1.
module fifo_sync_flags #(
    parameter int pckg_sz = 32,
    parameter int depth   = 16,
    parameter int af_thr  = depth - 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [pckg_sz-1:0]         D_push,
    output logic [pckg_sz-1:0]         D_pop,
    output logic                       pndng,
    output logic                       full,
    output logic                       almost_full,
    output logic [$clog2(depth+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int CW = $clog2(depth + 1);
    localparam int PW = (depth > 1) ? $clog2(depth) : 1;

    localparam logic [CW-1:0] DEPTH_C  = CW'(depth);
    localparam logic [CW-1:0] AF_C     = CW'(af_thr);
    localparam logic [PW-1:0] PTR_LAST = PW'(depth - 1);

    logic [pckg_sz-1:0] r_mem [depth];

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_pndng;
    logic          r_full;
    logic          r_almost_full;
    logic          r_overflow;
    logic          r_underflow;

    logic          w_push_ok;
    logic          w_pop_ok;
    logic [PW-1:0] w_wr_ptr_nxt;
    logic [PW-1:0] w_rd_ptr_nxt;
    logic [CW-1:0] w_count_nxt;

    // A pop in the same cycle frees the slot, so a push at full is still accepted.
    always_comb begin
        w_push_ok    = push & (~r_full | pop);
        w_pop_ok     = pop & r_pndng;
        w_wr_ptr_nxt = (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + PW'(1);
        w_rd_ptr_nxt = (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + PW'(1);
        w_count_nxt  = r_count;
        case ({w_push_ok, w_pop_ok})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_pndng       <= 1'b0;
            r_full        <= 1'b0;
            r_almost_full <= 1'b0;
            r_overflow    <= 1'b0;
            r_underflow   <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= w_wr_ptr_nxt;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= w_rd_ptr_nxt;
            end
            r_count       <= w_count_nxt;
            r_pndng       <= (w_count_nxt != '0);
            r_full        <= (w_count_nxt == DEPTH_C);
            r_almost_full <= (w_count_nxt >= AF_C);
            r_overflow    <= push & r_full & ~pop;
            r_underflow   <= pop & ~r_pndng;
        end
    end

    // Storage is deliberately left uncleared by reset.
    always_ff @(posedge clk) begin
        if (!rst && w_push_ok) begin
            r_mem[r_wr_ptr] <= D_push;
        end
    end

`ifdef FIFO_FWFT_EN
    assign D_pop = r_pndng ? r_mem[r_rd_ptr] : '0;
`else
    logic [pckg_sz-1:0] r_dout;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout <= '0;
        end else if (w_pop_ok) begin
            r_dout <= r_mem[r_rd_ptr];
        end
    end

    assign D_pop = r_dout;
`endif

    assign pndng       = r_pndng;
    assign full        = r_full;
    assign almost_full = r_almost_full;
    assign count       = r_count;
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Directed self-checking bench for fifo_sync_flags (depth=4, pckg_sz=8, af_thr=2).
// D_pop expectations carry both the registered-read and fall-through values.
module tb_fifo_sync_flags;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int AF = 2;
`ifdef FIFO_FWFT_EN
    localparam bit FWFT = 1'b1;
`else
    localparam bit FWFT = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         push;
    logic         pop;
    logic [W-1:0] D_push;
    logic [W-1:0] D_pop;
    logic         pndng;
    logic         full;
    logic         almost_full;
    logic [2:0]   count;
    logic         overflow;
    logic         underflow;

    int total = 0;
    int bad   = 0;

    fifo_sync_flags #(.pckg_sz(W), .depth(D), .af_thr(AF)) dut (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .pop         (pop),
        .D_push      (D_push),
        .D_pop       (D_pop),
        .pndng       (pndng),
        .full        (full),
        .almost_full (almost_full),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_d(input string tag, input logic [W-1:0] exp_reg, input logic [W-1:0] exp_fwft);
        chk(tag, 32'(D_pop), FWFT ? 32'(exp_fwft) : 32'(exp_reg));
    endtask

    task automatic chk_flags(input string tag, input int c, input bit pn, input bit fu,
                             input bit af, input bit ov, input bit un);
        chk({tag, ".count"},    32'(count),       32'(c));
        chk({tag, ".pndng"},    32'(pndng),       32'(pn));
        chk({tag, ".full"},     32'(full),        32'(fu));
        chk({tag, ".af"},       32'(almost_full), 32'(af));
        chk({tag, ".overflow"}, 32'(overflow),    32'(ov));
        chk({tag, ".underflow"},32'(underflow),   32'(un));
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic cyc(input bit r, input bit pu, input bit po, input logic [W-1:0] d);
        rst    = r;
        push   = pu;
        pop    = po;
        D_push = d;
        @(posedge clk);
        #1;
        rst  = 1'b0;
        push = 1'b0;
        pop  = 1'b0;
    endtask

    initial begin
        rst = 1'b0; push = 1'b0; pop = 1'b0; D_push = '0;
        #2;

        cyc(1, 0, 0, 8'h00);
        chk_flags("reset", 0, 0, 0, 0, 0, 0);
        chk_d("reset.dpop", 8'h00, 8'h00);
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 0, 8'h00);
            chk_flags("idle", 0, 0, 0, 0, 0, 0);
        end
        chk_d("idle.dpop", 8'h00, 8'h00);

        cyc(0, 1, 0, 8'h11);
        chk_flags("push1", 1, 1, 0, 0, 0, 0);
        chk_d("push1.dpop", 8'h00, 8'h11);
        cyc(0, 1, 0, 8'h22);
        chk_flags("push2", 2, 1, 0, 1, 0, 0);
        cyc(0, 1, 0, 8'h33);
        chk_flags("push3", 3, 1, 0, 1, 0, 0);
        cyc(0, 1, 0, 8'h44);
        chk_flags("push4", 4, 1, 1, 1, 0, 0);

        cyc(0, 1, 0, 8'h55);
        chk_flags("ovf", 4, 1, 1, 1, 1, 0);
        cyc(0, 0, 0, 8'h00);
        chk_flags("ovf.after", 4, 1, 1, 1, 0, 0);

        cyc(0, 1, 1, 8'h66);
        chk_flags("pushpop.full", 4, 1, 1, 1, 0, 0);
        chk_d("pushpop.dpop", 8'h11, 8'h22);

        cyc(0, 0, 1, 8'h00);
        chk_flags("drain1", 3, 1, 0, 1, 0, 0);
        chk_d("drain1.dpop", 8'h22, 8'h33);
        cyc(0, 0, 1, 8'h00);
        chk_flags("drain2", 2, 1, 0, 1, 0, 0);
        chk_d("drain2.dpop", 8'h33, 8'h44);
        cyc(0, 0, 1, 8'h00);
        chk_flags("drain3", 1, 1, 0, 0, 0, 0);
        chk_d("drain3.dpop", 8'h44, 8'h66);
        cyc(0, 0, 1, 8'h00);
        chk_flags("drain4", 0, 0, 0, 0, 0, 0);
        chk_d("drain4.dpop", 8'h66, 8'h00);

        cyc(0, 1, 1, 8'h77);
        chk_flags("empty.pushpop", 1, 1, 0, 0, 0, 1);
        chk_d("empty.pushpop.dpop", 8'h66, 8'h77);
        cyc(0, 0, 1, 8'h00);
        chk_flags("pop77", 0, 0, 0, 0, 0, 0);
        chk_d("pop77.dpop", 8'h77, 8'h00);
        cyc(0, 0, 1, 8'h00);
        chk_flags("unf", 0, 0, 0, 0, 0, 1);
        chk_d("unf.dpop", 8'h77, 8'h00);
        cyc(0, 0, 0, 8'h00);
        chk_flags("unf.after", 0, 0, 0, 0, 0, 0);

        cyc(0, 1, 0, 8'hAA);
        cyc(0, 1, 0, 8'hBB);
        cyc(0, 1, 0, 8'hCC);
        chk_flags("fill3", 3, 1, 0, 1, 0, 0);
        cyc(1, 1, 0, 8'hDD);
        chk_flags("rst.push", 0, 0, 0, 0, 0, 0);
        chk_d("rst.push.dpop", 8'h00, 8'h00);

        cyc(0, 1, 0, 8'h99);
        chk_flags("push99", 1, 1, 0, 0, 0, 0);
        chk_d("push99.dpop", 8'h00, 8'h99);
        cyc(0, 0, 1, 8'h00);
        chk_flags("pop99", 0, 0, 0, 0, 0, 0);
        chk_d("pop99.dpop", 8'h99, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
